// File: rtl/mips_pkg.sv
// Shared opcode/func encodings, forward-select codes and pipe-register records
// for the integer pipeline EX stage and its ALU.
// No ports; imported by execute_stage_if, alu_core and execute_stage.
package mips_pkg;

   localparam int XLEN = 32;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   // R-type func codes
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // Forward selects; 2'b11 behaves like FWD_REG
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // EX/MEM and MEM/WB contents; a bubble is all-zero
   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [4:0]      dest;
      logic            wen;
      logic            ovf;
   } pipe_reg_t;

   // ID/EX contents; rd and func live inside imm ([15:11] and [5:0])
   typedef struct packed {
      logic            valid;
      logic [5:0]      op;
      logic [4:0]      rt;
      logic [15:0]     imm;
      logic [XLEN-1:0] rs_val;
      logic [XLEN-1:0] rt_val;
   } idex_t;

   function automatic logic [XLEN-1:0] fwd_pick(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] reg_val,
                                                input logic [XLEN-1:0] exmem_val,
                                                input logic [XLEN-1:0] memwb_val);
      case (sel)
         FWD_EXMEM: fwd_pick = exmem_val;
         FWD_MEMWB: fwd_pick = memwb_val;
         default:   fwd_pick = reg_val;
      endcase
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of the EX stage's instruction/operand inputs, control inputs and
// pipe-register outputs. master = instruction source side, slave = execute_stage.
// Ports: instr_in, valid_in, rs_val, rt_val, stall, flush, forwardA/B in; exmem_*, memwb_* out.
interface execute_stage_if
   import mips_pkg::*;
#(
   parameter int W = XLEN
);
   logic [31:0]  instr_in;
   logic         valid_in;
   logic [W-1:0] rs_val;
   logic [W-1:0] rt_val;
   logic         stall;
   logic         flush;
   logic [1:0]   forwardA;
   logic [1:0]   forwardB;
   logic [W-1:0] exmem_result;
   logic [4:0]   exmem_dest;
   logic         exmem_wen;
   logic         exmem_ovf;
   logic [W-1:0] memwb_result;
   logic [4:0]   memwb_dest;
   logic         memwb_wen;

   modport master (
      output instr_in, valid_in, rs_val, rt_val, stall, flush, forwardA, forwardB,
      input  exmem_result, exmem_dest, exmem_wen, exmem_ovf,
      input  memwb_result, memwb_dest, memwb_wen
   );

   modport slave (
      input  instr_in, valid_in, rs_val, rt_val, stall, flush, forwardA, forwardB,
      output exmem_result, exmem_dest, exmem_wen, exmem_ovf,
      output memwb_result, memwb_dest, memwb_wen
   );
endinterface

// File: rtl/alu_core.sv
// Combinational integer ALU: decodes op/func and computes result, signed overflow
// (add/sub/addi only) and known (op/func recognised). Zero latency, no flow control.
// Ports: op, func, a, b in; result, ovf, known out. Unrecognised codes give result 0.
module alu_core
   import mips_pkg::*;
(
   input  logic [5:0]      op,
   input  logic [5:0]      func,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            ovf,
   output logic            known
);
   logic [XLEN-1:0] sum, diff;
   logic            add_ovf, sub_ovf, lt_s, lt_u;

   always_comb begin
      sum  = a + b;
      diff = a - b;
      // Overflow when operands agree in sign (add) / differ (sub) and the result sign flips
      add_ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1]  != a[XLEN-1]);
      sub_ovf = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      lt_s    = $signed(a) < $signed(b);
      lt_u    = a < b;

      result = '0;
      ovf    = 1'b0;
      known  = 1'b1;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADD:  begin result = sum;  ovf = add_ovf; end
               FN_ADDU: result = sum;
               FN_SUB:  begin result = diff; ovf = sub_ovf; end
               FN_SUBU: result = diff;
               FN_AND:  result = a & b;
               FN_OR:   result = a | b;
               FN_XOR:  result = a ^ b;
               FN_NOR:  result = ~(a | b);
               FN_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
               FN_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
               default: known = 1'b0;
            endcase
         end
         OP_ADDI:  begin result = sum; ovf = add_ovf; end
         OP_ADDIU: result = sum;
         OP_SLTI:  result = {{(XLEN-1){1'b0}}, lt_s};
         OP_ANDI:  result = a & b;
         OP_ORI:   result = a | b;
         OP_XORI:  result = a ^ b;
         OP_LUI:   result = b;   // b already holds imm<<16
         default:  known = 1'b0;
      endcase
   end
endmodule

// File: rtl/execute_stage.sv
// EX stage: ID/EX, EX/MEM and MEM/WB registers, immediate generator and forward muxes.
// Latency: instr_in at edge k -> exmem_* after k+1 -> memwb_* after k+2.
// stall holds ID/EX and bubbles EX/MEM; flush bubbles ID/EX (flush wins over stall).
// Ports: CLOCK, RESET (async, active-high), ex (execute_stage_if.slave).
module execute_stage
   import mips_pkg::*;
(
   input logic             CLOCK,
   input logic             RESET,
   execute_stage_if.slave  ex
);
   idex_t           idex_q;
   pipe_reg_t       exmem_q, memwb_q, ex_res;
   logic [XLEN-1:0] op_a, fwd_b, imm_x, op_b, alu_result;
   logic            alu_ovf, alu_known, is_rtype;
   logic [4:0]      ex_dest;

   always_comb begin
      is_rtype = (idex_q.op == OP_RTYPE);
      op_a     = fwd_pick(ex.forwardA, idex_q.rs_val, exmem_q.result, memwb_q.result);
      fwd_b    = fwd_pick(ex.forwardB, idex_q.rt_val, exmem_q.result, memwb_q.result);
      case (idex_q.op)
         OP_ADDI, OP_ADDIU, OP_SLTI: imm_x = {{(XLEN-16){idex_q.imm[15]}}, idex_q.imm};
         OP_LUI:                     imm_x = XLEN'({idex_q.imm, 16'h0000});
         default:                    imm_x = XLEN'(idex_q.imm);
      endcase
      // I-type ignores forwardB entirely
      op_b    = is_rtype ? fwd_b : imm_x;
      ex_dest = is_rtype ? idex_q.imm[15:11] : idex_q.rt;

      ex_res = '0;
      if (idex_q.valid && alu_known) begin
         ex_res.result = alu_result;
         ex_res.dest   = ex_dest;
         ex_res.wen    = (ex_dest != 5'd0);
         ex_res.ovf    = alu_ovf;
      end
   end

   alu_core u_alu (
      .op     (idex_q.op),
      .func   (idex_q.imm[5:0]),
      .a      (op_a),
      .b      (op_b),
      .result (alu_result),
      .ovf    (alu_ovf),
      .known  (alu_known)
   );

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         memwb_q <= exmem_q;
         if (ex.flush) begin
            idex_q  <= '0;
            exmem_q <= ex_res;
         end else if (ex.stall) begin
            exmem_q <= '0;
         end else begin
            idex_q.valid  <= ex.valid_in;
            idex_q.op     <= ex.instr_in[31:26];
            idex_q.rt     <= ex.instr_in[20:16];
            idex_q.imm    <= ex.instr_in[15:0];
            idex_q.rs_val <= ex.rs_val;
            idex_q.rt_val <= ex.rt_val;
            exmem_q       <= ex_res;
         end
      end
   end

   // rs index is resolved upstream (rs_val); ovf stops at EX/MEM
   logic unused_bits;
   assign unused_bits = ^{ex.instr_in[25:21], memwb_q.ovf};

   assign ex.exmem_result = exmem_q.result;
   assign ex.exmem_dest   = exmem_q.dest;
   assign ex.exmem_wen    = exmem_q.wen;
   assign ex.exmem_ovf    = exmem_q.ovf;
   assign ex.memwb_result = memwb_q.result;
   assign ex.memwb_dest   = memwb_q.dest;
   assign ex.memwb_wen    = memwb_q.wen;
endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
   logic CLOCK = 1'b0;
   logic RESET;
   always #5 CLOCK = ~CLOCK;

   execute_stage_if ex_bus ();
   execute_stage dut (.CLOCK(CLOCK), .RESET(RESET), .ex(ex_bus));

   int checks = 0;
   int failures = 0;

   // Reference model: pipeline contents as plain values
   logic        m_v;
   logic [31:0] m_ins, m_rs, m_rt;
   logic [31:0] m_em_res;  logic [4:0] m_em_dest; logic m_em_wen, m_em_ovf;
   logic [31:0] m_mw_res;  logic [4:0] m_mw_dest; logic m_mw_wen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
      rtype = {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      itype = {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic model_clear();
      m_v = 0; m_ins = 0; m_rs = 0; m_rt = 0;
      m_em_res = 0; m_em_dest = 0; m_em_wen = 0; m_em_ovf = 0;
      m_mw_res = 0; m_mw_dest = 0; m_mw_wen = 0;
   endtask

   // What the instruction now in ID/EX produces, from the ISA rules
   task automatic model_exec(output logic [31:0] r, output logic [4:0] d, output logic w, output logic o);
      logic [31:0] a, b, simm, zimm;
      logic [5:0]  op, fn;
      longint      sa, sb, full;
      logic        known, arith_ovf;
      a = (ex_bus.forwardA == 2'b10) ? m_em_res : (ex_bus.forwardA == 2'b01) ? m_mw_res : m_rs;
      b = (ex_bus.forwardB == 2'b10) ? m_em_res : (ex_bus.forwardB == 2'b01) ? m_mw_res : m_rt;
      op = m_ins[31:26]; fn = m_ins[5:0];
      simm = {{16{m_ins[15]}}, m_ins[15:0]};
      zimm = {16'h0, m_ins[15:0]};
      if (op != 6'h00) b = (op == 6'h0c || op == 6'h0d || op == 6'h0e) ? zimm : simm;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      known = 1; arith_ovf = 0; r = 0; full = 0;
      case (op)
         6'h00: case (fn)
            6'h20: begin r = a + b; full = sa + sb; arith_ovf = 1; end
            6'h21: r = a + b;
            6'h22: begin r = a - b; full = sa - sb; arith_ovf = 1; end
            6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
            6'h2b: r = (a < b) ? 32'd1 : 32'd0;
            default: known = 0;
         endcase
         6'h08: begin r = a + b; full = sa + sb; arith_ovf = 1; end
         6'h09: r = a + b;
         6'h0a: r = (sa < sb) ? 32'd1 : 32'd0;
         6'h0c: r = a & b;
         6'h0d: r = a | b;
         6'h0e: r = a ^ b;
         6'h0f: r = {m_ins[15:0], 16'h0};
         default: known = 0;
      endcase
      // Overflow: the true sum does not survive truncation to 32 bits
      o = arith_ovf && (full != longint'($signed(r)));
      d = (op == 6'h00) ? m_ins[15:11] : m_ins[20:16];
      w = (d != 0);
      if (!m_v || !known) begin r = 0; d = 0; w = 0; o = 0; end
   endtask

   task automatic compare_all();
      chk("exmem_result", ex_bus.exmem_result, m_em_res);
      chk("exmem_dest",   32'(ex_bus.exmem_dest), 32'(m_em_dest));
      chk("exmem_wen",    32'(ex_bus.exmem_wen),  32'(m_em_wen));
      chk("exmem_ovf",    32'(ex_bus.exmem_ovf),  32'(m_em_ovf));
      chk("memwb_result", ex_bus.memwb_result, m_mw_res);
      chk("memwb_dest",   32'(ex_bus.memwb_dest), 32'(m_mw_dest));
      chk("memwb_wen",    32'(ex_bus.memwb_wen),  32'(m_mw_wen));
   endtask

   // Advance model and DUT by one edge, then compare everything
   task automatic step();
      logic [31:0] r; logic [4:0] d; logic w, o;
      model_exec(r, d, w, o);
      m_mw_res = m_em_res; m_mw_dest = m_em_dest; m_mw_wen = m_em_wen;
      if (ex_bus.flush) begin
         m_em_res = r; m_em_dest = d; m_em_wen = w; m_em_ovf = o;
         m_v = 0; m_ins = 0; m_rs = 0; m_rt = 0;
      end else if (ex_bus.stall) begin
         m_em_res = 0; m_em_dest = 0; m_em_wen = 0; m_em_ovf = 0;
      end else begin
         m_em_res = r; m_em_dest = d; m_em_wen = w; m_em_ovf = o;
         m_v = ex_bus.valid_in; m_ins = ex_bus.instr_in; m_rs = ex_bus.rs_val; m_rt = ex_bus.rt_val;
      end
      @(posedge CLOCK);
      #1;
      compare_all();
   endtask

   task automatic cyc(input logic [31:0] ins, input logic v, input logic [31:0] rs, input logic [31:0] rt,
                      input logic st, input logic fl, input logic [1:0] fa, input logic [1:0] fb);
      ex_bus.instr_in = ins; ex_bus.valid_in = v; ex_bus.rs_val = rs; ex_bus.rt_val = rt;
      ex_bus.stall = st; ex_bus.flush = fl; ex_bus.forwardA = fa; ex_bus.forwardB = fb;
      step();
   endtask

   task automatic nop(input logic [1:0] fa, input logic [1:0] fb);
      cyc(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, fa, fb);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_exmem_result"}, ex_bus.exmem_result, 32'h0);
      chk({tag, "_exmem_dest"},   32'(ex_bus.exmem_dest), 32'h0);
      chk({tag, "_exmem_wen"},    32'(ex_bus.exmem_wen), 32'h0);
      chk({tag, "_exmem_ovf"},    32'(ex_bus.exmem_ovf), 32'h0);
      chk({tag, "_memwb_result"}, ex_bus.memwb_result, 32'h0);
      chk({tag, "_memwb_dest"},   32'(ex_bus.memwb_dest), 32'h0);
      chk({tag, "_memwb_wen"},    32'(ex_bus.memwb_wen), 32'h0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0: rand_val = 32'h0;
         1: rand_val = 32'h7FFFFFFF;
         2: rand_val = 32'h80000000;
         3: rand_val = 32'hFFFFFFFF;
         default: rand_val = $urandom;
      endcase
   endfunction

   logic [5:0] rfuncs [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
   logic [5:0] iops   [7]  = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};

   initial begin
      logic [31:0] ins;
      int k;
      ex_bus.instr_in = 0; ex_bus.valid_in = 0; ex_bus.rs_val = 0; ex_bus.rt_val = 0;
      ex_bus.stall = 0; ex_bus.flush = 0; ex_bus.forwardA = 0; ex_bus.forwardB = 0;
      model_clear();
      RESET = 1'b1;
      repeat (2) @(posedge CLOCK);
      #1;
      chk_outputs_zero("reset");
      RESET = 1'b0;

      // add $3,$1,$2 : 5 + 7
      cyc(rtype(1, 2, 3, 6'h20), 1, 5, 7, 0, 0, 2'b00, 2'b00);
      nop(2'b00, 2'b00);
      chk("add_exmem_result", ex_bus.exmem_result, 32'd12);
      chk("add_exmem_dest", 32'(ex_bus.exmem_dest), 32'd3);
      chk("add_exmem_wen", 32'(ex_bus.exmem_wen), 32'd1);
      nop(2'b00, 2'b00);
      chk("add_memwb_result", ex_bus.memwb_result, 32'd12);
      chk("add_memwb_wen", 32'(ex_bus.memwb_wen), 32'd1);

      // Back-to-back dependency through EX/MEM
      cyc(rtype(1, 2, 3, 6'h20), 1, 5, 7, 0, 0, 2'b00, 2'b00);
      cyc(rtype(3, 1, 4, 6'h22), 1, 0, 1, 0, 0, 2'b00, 2'b00);
      nop(2'b10, 2'b00);
      chk("fwd_exmem_result", ex_bus.exmem_result, 32'd11);
      chk("fwd_exmem_dest", 32'(ex_bus.exmem_dest), 32'd4);

      // Dependency one instruction apart, through MEM/WB
      cyc(rtype(1, 2, 3, 6'h20), 1, 5, 7, 0, 0, 2'b00, 2'b00);
      cyc(rtype(0, 0, 5, 6'h25), 1, 0, 0, 0, 0, 2'b00, 2'b00);
      cyc(rtype(3, 1, 4, 6'h22), 1, 0, 1, 0, 0, 2'b00, 2'b00);
      nop(2'b01, 2'b00);
      chk("fwd_memwb_result", ex_bus.exmem_result, 32'd11);

      // Immediates
      cyc(itype(6'h0d, 0, 5, 16'h8000), 1, 0, 0, 0, 0, 2'b00, 2'b00);
      cyc(itype(6'h08, 0, 6, 16'hFFFF), 1, 0, 0, 0, 0, 2'b00, 2'b00);
      chk("ori_result", ex_bus.exmem_result, 32'h00008000);
      cyc(itype(6'h0f, 0, 7, 16'h1234), 1, 0, 0, 0, 0, 2'b00, 2'b00);
      chk("addi_result", ex_bus.exmem_result, 32'hFFFFFFFF);
      cyc(itype(6'h0a, 0, 8, 16'hFFFF), 1, 0, 0, 0, 0, 2'b00, 2'b00);
      chk("lui_result", ex_bus.exmem_result, 32'h12340000);
      nop(2'b00, 2'b00);
      chk("slti_result", ex_bus.exmem_result, 32'h0);
      chk("slti_wen", 32'(ex_bus.exmem_wen), 32'd1);

      // Overflow, $0 destination, unknown func
      cyc(rtype(1, 2, 3, 6'h20), 1, 32'h7FFFFFFF, 1, 0, 0, 2'b00, 2'b00);
      cyc(rtype(1, 2, 0, 6'h20), 1, 1, 1, 0, 0, 2'b00, 2'b00);
      chk("ovf_result", ex_bus.exmem_result, 32'h80000000);
      chk("ovf_flag", 32'(ex_bus.exmem_ovf), 32'd1);
      cyc(rtype(1, 2, 9, 6'h3f), 1, 3, 4, 0, 0, 2'b00, 2'b00);
      chk("dest0_wen", 32'(ex_bus.exmem_wen), 32'd0);
      nop(2'b00, 2'b00);
      chk("unknown_result", ex_bus.exmem_result, 32'h0);
      chk("unknown_wen", 32'(ex_bus.exmem_wen), 32'd0);

      // Stall two cycles
      cyc(rtype(1, 2, 9, 6'h20), 1, 3, 4, 0, 0, 2'b00, 2'b00);
      cyc(rtype(1, 2, 10, 6'h25), 1, 1, 2, 1, 0, 2'b00, 2'b00);
      chk("stall1_wen", 32'(ex_bus.exmem_wen), 32'd0);
      cyc(rtype(1, 2, 10, 6'h25), 1, 1, 2, 1, 0, 2'b00, 2'b00);
      chk("stall2_wen", 32'(ex_bus.exmem_wen), 32'd0);
      cyc(rtype(1, 2, 10, 6'h25), 1, 1, 2, 0, 0, 2'b00, 2'b00);
      chk("stall_held_result", ex_bus.exmem_result, 32'd7);
      chk("stall_held_dest", 32'(ex_bus.exmem_dest), 32'd9);
      nop(2'b00, 2'b00);
      chk("stall_next_dest", 32'(ex_bus.exmem_dest), 32'd10);
      chk("stall_next_result", ex_bus.exmem_result, 32'd3);

      // Flush
      nop(2'b00, 2'b00);
      cyc(rtype(1, 2, 11, 6'h20), 1, 1, 1, 0, 1, 2'b00, 2'b00);
      nop(2'b00, 2'b00);
      chk("flush_exmem_wen", 32'(ex_bus.exmem_wen), 32'd0);
      nop(2'b00, 2'b00);
      chk("flush_memwb_wen", 32'(ex_bus.memwb_wen), 32'd0);

      // Stall and flush together
      cyc(rtype(1, 2, 12, 6'h20), 1, 2, 3, 0, 0, 2'b00, 2'b00);
      cyc(rtype(1, 2, 13, 6'h20), 1, 5, 5, 1, 1, 2'b00, 2'b00);
      chk("sf_exmem_result", ex_bus.exmem_result, 32'd5);
      chk("sf_exmem_dest", 32'(ex_bus.exmem_dest), 32'd12);
      nop(2'b00, 2'b00);
      chk("sf_bubble_wen", 32'(ex_bus.exmem_wen), 32'd0);

      // Reset mid-stream
      cyc(rtype(1, 2, 14, 6'h20), 1, 9, 9, 0, 0, 2'b00, 2'b00);
      cyc(rtype(1, 2, 15, 6'h20), 1, 8, 8, 0, 0, 2'b00, 2'b00);
      #1;
      RESET = 1'b1;
      #1;
      chk_outputs_zero("midreset");
      model_clear();
      ex_bus.valid_in = 0; ex_bus.instr_in = 0;
      @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      cyc(rtype(1, 2, 3, 6'h20), 1, 5, 7, 0, 0, 2'b00, 2'b00);
      chk("postreset_edge1_wen", 32'(ex_bus.exmem_wen), 32'd0);
      nop(2'b00, 2'b00);
      chk("postreset_edge2_result", ex_bus.exmem_result, 32'd12);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         k = $urandom_range(0, 19);
         if (k < 10)
            ins = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7), rfuncs[k]);
         else if (k < 17)
            ins = itype(iops[k-10], $urandom_range(0, 31), $urandom_range(0, 7), 16'($urandom));
         else
            ins = $urandom;
         cyc(ins, ($urandom_range(0, 9) != 0), rand_val(), rand_val(),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
